// File: rtl/led_fade_scheduler.sv
// Multi-channel LED fade controller.
// Fade commands arrive over a valid/ready handshake. A single ramp engine is
// shared by all channels: on every prescaled tick it walks the channels in
// index order and moves each busy channel's duty toward its target. A shared
// free-running 8-bit counter turns each duty value into a PWM output.
//
// Parameter constraints (not checked in hardware):
//   2 <= NCH <= 8, CLK_DIV >= NCH+2, 2**DIV_W >= CLK_DIV.
module led_fade_scheduler #(
  parameter int NCH     = 4,
  parameter int CLK_DIV = 50000,
  parameter int DIV_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [2:0]       req_ch,
  input  logic [7:0]       req_target,
  input  logic [7:0]       req_step,
  output logic             req_ready,
  output logic [NCH-1:0]   led,
  output logic [8*NCH-1:0] duty_flat,
  output logic [NCH-1:0]   busy,
  output logic             done_pulse,
  output logic [2:0]       done_ch
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Prescaler
  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;
  logic             tick;

  // PWM
  logic [7:0]       pwm_cnt_q;
  logic [NCH-1:0]   led_q;
  logic [NCH-1:0]   led_d;

  // Scan FSM
  state_t           state_q;
  state_t           state_d;
  logic [2:0]       idx_q;
  logic [2:0]       idx_d;
  logic             scan_en;

  // Per-channel ramp state
  logic [7:0]       duty_q   [NCH];
  logic [7:0]       target_q [NCH];
  logic [7:0]       step_q   [NCH];
  logic [NCH-1:0]   busy_q;

  // Completion pulse
  logic             done_pulse_q;
  logic [2:0]       done_ch_q;

  // Command path
  logic             accept;
  logic [NCH-1:0]   acc_sel;
  logic             acc_hit;
  logic [7:0]       acc_duty;
  logic             acc_done;
  logic [7:0]       eff_step;

  // Ramp engine path (channel idx_q)
  logic [NCH-1:0]   scan_sel;
  logic [7:0]       cur_duty;
  logic [7:0]       cur_target;
  logic [7:0]       cur_step;
  logic             cur_busy;
  logic [8:0]       up_sum;
  logic [8:0]       down_floor;
  logic [7:0]       ramp_duty;
  logic             scan_done;

  // ---------------------------------------------------------------------------
  // Prescaler: counts 0..CLK_DIV-1, tick on the terminal count
  // ---------------------------------------------------------------------------
  assign tick = (presc_q == DIV_W'(CLK_DIV - 1));

  // Next prescaler value with wrap on the terminal count
  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) begin
      presc_d = '0;
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM: shared free-running counter, registered compare per channel
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_pwm
      assign led_d[gi]              = (pwm_cnt_q < duty_q[gi]);
      assign duty_flat[8*gi +: 8]   = duty_q[gi];
    end
  endgenerate

  // PWM counter and registered LED outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

  // ---------------------------------------------------------------------------
  // Scan FSM: IDLE accepts commands; SCAN visits one channel per cycle
  // ---------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (idx_q == 3'(NCH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output logic: commands only in IDLE, ramp engine only in SCAN
  always_comb begin
    req_ready = 1'b0;
    scan_en   = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_SCAN: scan_en   = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command decode: out-of-range channels are handshaken but select nothing
  // ---------------------------------------------------------------------------
  assign accept   = req_valid && req_ready;
  assign eff_step = (req_step == 8'd0) ? 8'd1 : req_step;

  generate
    for (gi = 0; gi < NCH; gi++) begin : g_sel
      assign acc_sel[gi]  = accept && (req_ch == 3'(gi));
      assign scan_sel[gi] = scan_en && (idx_q == 3'(gi)) && busy_q[gi];
    end
  endgenerate

  assign acc_hit = |acc_sel;

  // Current duty of the commanded channel
  always_comb begin
    acc_duty = 8'd0;
    for (int i = 0; i < NCH; i++) begin
      if (acc_sel[i]) begin
        acc_duty = duty_q[i];
      end
    end
  end

  // A command whose target already equals the duty completes immediately
  assign acc_done = acc_hit && (req_target == acc_duty);

  // ---------------------------------------------------------------------------
  // Ramp engine for channel idx_q
  // ---------------------------------------------------------------------------

  // Select the state of the channel under scan
  always_comb begin
    cur_duty   = 8'd0;
    cur_target = 8'd0;
    cur_step   = 8'd0;
    cur_busy   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == 3'(i)) begin
        cur_duty   = duty_q[i];
        cur_target = target_q[i];
        cur_step   = step_q[i];
        cur_busy   = busy_q[i];
      end
    end
  end

  // One ramp step, clamped at the target; 9-bit math avoids wrap either way
  always_comb begin
    up_sum     = {1'b0, cur_duty} + {1'b0, cur_step};
    down_floor = {1'b0, cur_target} + {1'b0, cur_step};
    ramp_duty  = cur_target;
    if (cur_duty < cur_target) begin
      if (up_sum < {1'b0, cur_target}) begin
        ramp_duty = up_sum[7:0];
      end
    end else if (cur_duty > cur_target) begin
      if ({1'b0, cur_duty} > down_floor) begin
        ramp_duty = cur_duty - cur_step;
      end
    end
  end

  assign scan_done = scan_en && cur_busy && (ramp_duty == cur_target);

  // Per-channel registers: command writes (IDLE only) and ramp updates (SCAN only)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        duty_q[i]   <= 8'd0;
        target_q[i] <= 8'd0;
        step_q[i]   <= 8'd0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (acc_sel[i]) begin
          target_q[i] <= req_target;
          step_q[i]   <= eff_step;
          busy_q[i]   <= (req_target != duty_q[i]);
        end else if (scan_sel[i]) begin
          duty_q[i] <= ramp_duty;
          if (ramp_duty == target_q[i]) begin
            busy_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign busy = busy_q;

  // ---------------------------------------------------------------------------
  // Completion pulse: accepts and scans never overlap, so one source at a time
  // ---------------------------------------------------------------------------

  // Register the completion event one cycle after it is detected
  always_ff @(posedge clk) begin
    if (rst) begin
      done_pulse_q <= 1'b0;
      done_ch_q    <= '0;
    end else begin
      done_pulse_q <= acc_done || scan_done;
      if (scan_done) begin
        done_ch_q <= idx_q;
      end else if (acc_done) begin
        done_ch_q <= req_ch;
      end
    end
  end

  assign done_pulse = done_pulse_q;
  assign done_ch    = done_ch_q;

endmodule
